// File: rtl/data_memory_load_tracker_if.sv
//==============================================================================
// Module   : data_memory_load_tracker_if
// Brief    : Execution-side inputs and DM-stage / retire outputs of the load tracker.
// Revision : 1.0
//==============================================================================
`default_nettype none

interface data_memory_load_tracker_if #(
   parameter int REG_ADD_WIDTH     = 5,
   parameter int D_CACHE_LW_WIDTH  = 3,
   parameter int STALL_COUNT_WIDTH = 32
);
   logic [D_CACHE_LW_WIDTH-1:0]  DATA_CACHE_LOAD_EXECUTION;
   logic [REG_ADD_WIDTH-1:0]     RD_ADDRESS_EXECUTION;
   logic                         CLEAR_EXECUTION_STAGE;
   logic                         STALL_DATA_MEMORY_STAGE;
   logic                         DATA_CACHE_READY;
   logic [D_CACHE_LW_WIDTH-1:0]  DATA_CACHE_LOAD_DM1;
   logic [D_CACHE_LW_WIDTH-1:0]  DATA_CACHE_LOAD_DM2;
   logic [D_CACHE_LW_WIDTH-1:0]  DATA_CACHE_LOAD_DM3;
   logic [REG_ADD_WIDTH-1:0]     RD_ADDRESS_DM1;
   logic [REG_ADD_WIDTH-1:0]     RD_ADDRESS_DM2;
   logic [REG_ADD_WIDTH-1:0]     RD_ADDRESS_DM3;
   logic                         LOAD_RETIRE_VALID;
   logic [D_CACHE_LW_WIDTH-1:0]  LOAD_RETIRE_TYPE;
   logic [REG_ADD_WIDTH-1:0]     LOAD_RETIRE_RD;
   logic [1:0]                   PENDING_LOAD_COUNT;
   logic [STALL_COUNT_WIDTH-1:0] STALL_CYCLE_COUNT;

   modport master (
      output DATA_CACHE_LOAD_EXECUTION, RD_ADDRESS_EXECUTION, CLEAR_EXECUTION_STAGE,
             STALL_DATA_MEMORY_STAGE, DATA_CACHE_READY,
      input  DATA_CACHE_LOAD_DM1, DATA_CACHE_LOAD_DM2, DATA_CACHE_LOAD_DM3,
             RD_ADDRESS_DM1, RD_ADDRESS_DM2, RD_ADDRESS_DM3,
             LOAD_RETIRE_VALID, LOAD_RETIRE_TYPE, LOAD_RETIRE_RD,
             PENDING_LOAD_COUNT, STALL_CYCLE_COUNT
   );

   modport slave (
      input  DATA_CACHE_LOAD_EXECUTION, RD_ADDRESS_EXECUTION, CLEAR_EXECUTION_STAGE,
             STALL_DATA_MEMORY_STAGE, DATA_CACHE_READY,
      output DATA_CACHE_LOAD_DM1, DATA_CACHE_LOAD_DM2, DATA_CACHE_LOAD_DM3,
             RD_ADDRESS_DM1, RD_ADDRESS_DM2, RD_ADDRESS_DM3,
             LOAD_RETIRE_VALID, LOAD_RETIRE_TYPE, LOAD_RETIRE_RD,
             PENDING_LOAD_COUNT, STALL_CYCLE_COUNT
   );
endinterface

`default_nettype wire

// File: rtl/data_memory_load_tracker.sv
//==============================================================================
// Module   : data_memory_load_tracker
// Brief    : Tracks loads through DM1..DM3 for hazard detection, pulses on retire.
// Revision : 1.0
//==============================================================================
`default_nettype none

module data_memory_load_tracker #(
   parameter int                    REG_ADD_WIDTH        = 5,
   parameter int                    D_CACHE_LW_WIDTH     = 3,
   parameter logic [D_CACHE_LW_WIDTH-1:0] DATA_CACHE_LOAD_NONE = 3'b000,
   parameter int                    STALL_COUNT_WIDTH    = 32
) (
   input wire logic                  CLK,
   input wire logic                  RESET,
   data_memory_load_tracker_if.slave bus
);

   logic [D_CACHE_LW_WIDTH-1:0]  r_type_dm1, r_type_dm2, r_type_dm3;
   logic [REG_ADD_WIDTH-1:0]     r_rd_dm1, r_rd_dm2, r_rd_dm3;
   logic                         r_retire_valid;
   logic [D_CACHE_LW_WIDTH-1:0]  r_retire_type;
   logic [REG_ADD_WIDTH-1:0]     r_retire_rd;
   logic [1:0]                   r_pending;
   logic [STALL_COUNT_WIDTH-1:0] r_stall_count;

   logic                         w_advance;
   logic                         w_cand_valid;
   logic [D_CACHE_LW_WIDTH-1:0]  w_cand_type;
   logic [REG_ADD_WIDTH-1:0]     w_cand_rd;
   logic [1:0]                   w_next_pending;

   assign w_advance = bus.DATA_CACHE_READY & ~bus.STALL_DATA_MEMORY_STAGE;

   // Loads to x0 are dropped so that rs=x0 can never match a tracked destination.
   assign w_cand_valid = ~bus.CLEAR_EXECUTION_STAGE
                       & (bus.RD_ADDRESS_EXECUTION != '0)
                       & (bus.DATA_CACHE_LOAD_EXECUTION != DATA_CACHE_LOAD_NONE);
   assign w_cand_type  = w_cand_valid ? bus.DATA_CACHE_LOAD_EXECUTION : DATA_CACHE_LOAD_NONE;
   assign w_cand_rd    = w_cand_valid ? bus.RD_ADDRESS_EXECUTION : '0;

   // Occupancy after a shift: new DM1 plus the old DM1/DM2 moving down.
   assign w_next_pending = {1'b0, w_cand_valid}
                         + {1'b0, (r_type_dm1 != DATA_CACHE_LOAD_NONE)}
                         + {1'b0, (r_type_dm2 != DATA_CACHE_LOAD_NONE)};

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_type_dm1     <= DATA_CACHE_LOAD_NONE;
         r_type_dm2     <= DATA_CACHE_LOAD_NONE;
         r_type_dm3     <= DATA_CACHE_LOAD_NONE;
         r_rd_dm1       <= '0;
         r_rd_dm2       <= '0;
         r_rd_dm3       <= '0;
         r_retire_valid <= 1'b0;
         r_retire_type  <= DATA_CACHE_LOAD_NONE;
         r_retire_rd    <= '0;
         r_pending      <= 2'd0;
         r_stall_count  <= '0;
      end else if (w_advance) begin
         r_type_dm1     <= w_cand_type;
         r_rd_dm1       <= w_cand_rd;
         r_type_dm2     <= r_type_dm1;
         r_rd_dm2       <= r_rd_dm1;
         r_type_dm3     <= r_type_dm2;
         r_rd_dm3       <= r_rd_dm2;
         r_retire_valid <= (r_type_dm3 != DATA_CACHE_LOAD_NONE);
         r_retire_type  <= r_type_dm3;
         r_retire_rd    <= r_rd_dm3;
         r_pending      <= w_next_pending;
      end else begin
         r_retire_valid <= 1'b0;
         r_stall_count  <= r_stall_count + STALL_COUNT_WIDTH'(1);
      end
   end

   assign bus.DATA_CACHE_LOAD_DM1 = r_type_dm1;
   assign bus.DATA_CACHE_LOAD_DM2 = r_type_dm2;
   assign bus.DATA_CACHE_LOAD_DM3 = r_type_dm3;
   assign bus.RD_ADDRESS_DM1      = r_rd_dm1;
   assign bus.RD_ADDRESS_DM2      = r_rd_dm2;
   assign bus.RD_ADDRESS_DM3      = r_rd_dm3;
   assign bus.LOAD_RETIRE_VALID   = r_retire_valid;
   assign bus.LOAD_RETIRE_TYPE    = r_retire_type;
   assign bus.LOAD_RETIRE_RD      = r_retire_rd;
   assign bus.PENDING_LOAD_COUNT  = r_pending;
   assign bus.STALL_CYCLE_COUNT   = r_stall_count;

endmodule

`default_nettype wire
